// File: rtl/dsm_mash_cfg.sv
// Run-time order-selectable MASH1 / MASH1-1 / MASH1-1-1 modulator producing a
// clamped MMD divide word and the signed phase residue. Optional dither: DSM_DITHER_EN.
module dsm_mash_cfg #(
  parameter int WI      = 6,
  parameter int WF      = 16,
  parameter int MMD_MIN = 4,
  parameter int MMD_MAX = 63
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             EN,
  input  logic [WI+WF-1:0] FCW,
  input  logic [1:0]       MODE,
  input  logic             CFG_LD,
  output logic [WI-1:0]    MMD_DCW,
  output logic [3:0]       DSM_OUT,
  output logic [WF+2:0]    PHE,
  output logic             SAT
);

  typedef enum logic [1:0] {
    MODE_MASH1   = 2'd0,
    MODE_MASH11  = 2'd1,
    MODE_MASH111 = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  localparam logic [WI-1:0]        DCW_MIN = MMD_MIN[WI-1:0];
  localparam logic [WI-1:0]        DCW_MAX = MMD_MAX[WI-1:0];
  localparam logic signed [WI+1:0] D_MIN   = MMD_MIN[WI+1:0];
  localparam logic signed [WI+1:0] D_MAX   = MMD_MAX[WI+1:0];

  logic [WI+WF-1:0] fcw_s_q, fcw_s_d;
  mode_e            mode_s_q, mode_s_d;
  logic [WF-1:0]    acc1_q, acc1_d, acc2_q, acc2_d, acc3_q, acc3_d;
  logic             c2_d1_q, c2_d1_d, c3_d1_q, c3_d1_d, c3_d2_q, c3_d2_d;
  logic [WI-1:0]    mmd_dcw_q, mmd_dcw_d;
  logic [3:0]       dsm_out_q, dsm_out_d;
  logic [WF+2:0]    phe_q, phe_d;
  logic             sat_q, sat_d;

  logic             dith_bit;
  logic             stage2_on, stage3_on;
  logic [WF-1:0]    f_frac;
  logic [WI-1:0]    f_int;
  logic [WF:0]      sum1, sum2, sum3;
  logic             c1, c2, c3;
  logic [3:0]       y;
  logic [WI+1:0]    d_raw;
  logic             d_lo, d_hi;
  logic [WI-1:0]    dcw_next;

`ifdef DSM_DITHER_EN
  logic [14:0] lfsr_q, lfsr_d;

  always_comb begin
    dith_bit = lfsr_q[0];
    lfsr_d   = EN ? {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]} : lfsr_q;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) lfsr_q <= 15'h0001;
    else       lfsr_q <= lfsr_d;
  end
`else
  always_comb dith_bit = 1'b0;
`endif

  always_comb begin
    stage2_on = (mode_s_q != MODE_MASH1);
    stage3_on = (mode_s_q == MODE_MASH111) || (mode_s_q == MODE_RSVD);
    f_frac    = fcw_s_q[WF-1:0];
    f_int     = fcw_s_q[WI+WF-1:WF];

    sum1 = {1'b0, acc1_q} + {1'b0, f_frac} + {{WF{1'b0}}, dith_bit};
    sum2 = stage2_on ? ({1'b0, acc2_q} + {1'b0, sum1[WF-1:0]}) : '0;
    sum3 = stage3_on ? ({1'b0, acc3_q} + {1'b0, sum2[WF-1:0]}) : '0;
    c1   = sum1[WF];
    c2   = sum2[WF];
    c3   = sum3[WF];

    // 4-bit wrap is exact: the cancelled sum always lies in -3..+4
    y = {3'b000, c1} + {3'b000, c2} - {3'b000, c2_d1_q}
      + {3'b000, c3} - {2'b00, c3_d1_q, 1'b0} + {3'b000, c3_d2_q};

    d_raw    = {2'b00, f_int} + {{(WI-2){y[3]}}, y};
    d_lo     = $signed(d_raw) < D_MIN;
    d_hi     = $signed(d_raw) > D_MAX;
    dcw_next = d_lo ? DCW_MIN : (d_hi ? DCW_MAX : d_raw[WI-1:0]);

    // Residue is modulo 2^(WF+3), so only the low bits of each term matter
    phe_d = phe_q + fcw_s_q[WF+2:0] - {dcw_next[2:0], {WF{1'b0}}};

    fcw_s_d   = fcw_s_q;
    mode_s_d  = mode_s_q;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    acc3_d    = acc3_q;
    c2_d1_d   = c2_d1_q;
    c3_d1_d   = c3_d1_q;
    c3_d2_d   = c3_d2_q;
    mmd_dcw_d = mmd_dcw_q;
    dsm_out_d = dsm_out_q;
    sat_d     = sat_q;

    if (EN) begin
      acc1_d    = sum1[WF-1:0];
      acc2_d    = sum2[WF-1:0];
      acc3_d    = sum3[WF-1:0];
      c2_d1_d   = c2;
      c3_d1_d   = c3;
      c3_d2_d   = c3_d1_q;
      mmd_dcw_d = dcw_next;
      dsm_out_d = y;
      sat_d     = d_lo | d_hi;
    end else begin
      phe_d = phe_q;
    end

    // Higher-stage clear wins over the EN update; acc1/PHE continue untouched
    if (CFG_LD) begin
      fcw_s_d  = FCW;
      mode_s_d = mode_e'(MODE);
      if (mode_e'(MODE) != mode_s_q) begin
        acc2_d  = '0;
        acc3_d  = '0;
        c2_d1_d = 1'b0;
        c3_d1_d = 1'b0;
        c3_d2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      fcw_s_q   <= {DCW_MIN, {WF{1'b0}}};
      mode_s_q  <= MODE_MASH1;
      acc1_q    <= '0;
      acc2_q    <= '0;
      acc3_q    <= '0;
      c2_d1_q   <= 1'b0;
      c3_d1_q   <= 1'b0;
      c3_d2_q   <= 1'b0;
      mmd_dcw_q <= DCW_MIN;
      dsm_out_q <= '0;
      phe_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      fcw_s_q   <= fcw_s_d;
      mode_s_q  <= mode_s_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      acc3_q    <= acc3_d;
      c2_d1_q   <= c2_d1_d;
      c3_d1_q   <= c3_d1_d;
      c3_d2_q   <= c3_d2_d;
      mmd_dcw_q <= mmd_dcw_d;
      dsm_out_q <= dsm_out_d;
      phe_q     <= phe_d;
      sat_q     <= sat_d;
    end
  end

  assign MMD_DCW = mmd_dcw_q;
  assign DSM_OUT = dsm_out_q;
  assign PHE     = phe_q;
  assign SAT     = sat_q;

endmodule

// File: tb/tb_dsm_mash_cfg.sv
// Self-checking bench for dsm_mash_cfg: constant vector table, directed corner
// sequences and randomized stimulus against an integer-arithmetic reference model.
module tb_dsm_mash_cfg;

  localparam int WI = 6;
  localparam int WF = 16;
  localparam int ONE = 1 << WF;

  logic          CLK = 1'b0;
  logic          NRST, EN, CFG_LD;
  logic [21:0]   FCW;
  logic [1:0]    MODE;
  logic [5:0]    MMD_DCW;
  logic [3:0]    DSM_OUT;
  logic [18:0]   PHE;
  logic          SAT;

  int n_chk = 0;
  int n_fail = 0;

  dsm_mash_cfg #(.WI(WI), .WF(WF), .MMD_MIN(4), .MMD_MAX(63)) dut (
    .CLK(CLK), .NRST(NRST), .EN(EN), .FCW(FCW), .MODE(MODE), .CFG_LD(CFG_LD),
    .MMD_DCW(MMD_DCW), .DSM_OUT(DSM_OUT), .PHE(PHE), .SAT(SAT)
  );

  always #5 CLK = ~CLK;

  // Reference model: integer fractions in units of 2^-16
  int m_fcw, m_mode, m_acc1, m_acc2, m_acc3, m_c2d1, m_c3d1, m_c3d2;
  int m_phe, m_dcw, m_y, m_sat, m_lfsr;

  function automatic int wrap19(input int v);
    int m;
    m = v & ((1 << 19) - 1);
    if (m >= (1 << 18)) m -= (1 << 19);
    return m;
  endfunction

  task automatic model_reset();
    m_fcw = 4 * ONE; m_mode = 0;
    m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
    m_c2d1 = 0; m_c3d1 = 0; m_c3d2 = 0;
    m_phe = 0; m_dcw = 4; m_y = 0; m_sat = 0; m_lfsr = 1;
  endtask

  task automatic model_step(input logic en, input logic ld, input int fcw, input int mode);
    int order, f, i, dith, t, c1, c2, c3, s1, s2, s3, d;
    order = (m_mode == 3) ? 2 : m_mode;
    if (en) begin
      f = m_fcw % ONE;
      i = m_fcw / ONE;
      dith = 0;
`ifdef DSM_DITHER_EN
      dith = m_lfsr & 1;
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7FFF;
`endif
      t = m_acc1 + f + dith; c1 = t / ONE; s1 = t % ONE;
      c2 = 0; s2 = 0; c3 = 0; s3 = 0;
      if (order >= 1) begin t = m_acc2 + s1; c2 = t / ONE; s2 = t % ONE; end
      if (order >= 2) begin t = m_acc3 + s2; c3 = t / ONE; s3 = t % ONE; end
      m_y = c1 + (c2 - m_c2d1) + (c3 - 2 * m_c3d1 + m_c3d2);
      d = i + m_y;
      m_sat = (d < 4 || d > 63) ? 1 : 0;
      m_dcw = (d < 4) ? 4 : ((d > 63) ? 63 : d);
      m_phe = wrap19(m_phe + m_fcw - m_dcw * ONE);
      m_acc1 = s1; m_acc2 = s2; m_acc3 = s3;
      m_c3d2 = m_c3d1; m_c3d1 = c3; m_c2d1 = c2;
    end
    if (ld) begin
      if (mode != m_mode) begin
        m_acc2 = 0; m_acc3 = 0; m_c2d1 = 0; m_c3d1 = 0; m_c3d2 = 0;
      end
      m_fcw = fcw; m_mode = mode;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dcw"}, int'(MMD_DCW), m_dcw);
    chk({tag, "_dsm"}, int'($signed(DSM_OUT)), m_y);
    chk({tag, "_phe"}, int'($signed(PHE)), m_phe);
    chk({tag, "_sat"}, int'(SAT), m_sat);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dcw"}, int'(MMD_DCW), 4);
    chk({tag, "_dsm"}, int'($signed(DSM_OUT)), 0);
    chk({tag, "_phe"}, int'($signed(PHE)), 0);
    chk({tag, "_sat"}, int'(SAT), 0);
  endtask

  task automatic apply(input logic en, input logic ld, input logic [21:0] fcw, input logic [1:0] mode);
    EN = en; CFG_LD = ld; FCW = fcw; MODE = mode;
    model_step(en, ld, int'(fcw), int'(mode));
    @(posedge CLK);
    #1;
  endtask

  task automatic async_reset(input string tag);
    #2 NRST = 1'b0;
    #1 check_reset(tag);
    model_reset();
    #2 NRST = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic        ld;
    logic [21:0] fcw;
    logic [1:0]  mode;
    int          dcw;
    int          phe;
    int          sat;
    int          y;
  } vec_t;

  vec_t t1[9];

  task automatic run_t1(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      apply(t1[k].en, t1[k].ld, t1[k].fcw, t1[k].mode);
      chk($sformatf("%s_dcw%0d", tag, k), int'(MMD_DCW), t1[k].dcw);
      chk($sformatf("%s_phe%0d", tag, k), int'($signed(PHE)), t1[k].phe);
      chk($sformatf("%s_sat%0d", tag, k), int'(SAT), t1[k].sat);
      chk($sformatf("%s_dsm%0d", tag, k), int'($signed(DSM_OUT)), t1[k].y);
    end
  endtask

  initial begin
    int ysum, bad, sat_seen;
    logic en_r, ld_r;
    logic [21:0] fcw_r;

    t1[0] = '{1'b0, 1'b1, 22'h064000, 2'd0, 4, 0,       0, 0};
    t1[1] = '{1'b1, 1'b0, 22'h064000, 2'd0, 6, 'h4000, 0, 0};
    t1[2] = '{1'b1, 1'b0, 22'h064000, 2'd0, 6, 'h8000, 0, 0};
    t1[3] = '{1'b1, 1'b0, 22'h064000, 2'd0, 6, 'hC000, 0, 0};
    t1[4] = '{1'b1, 1'b0, 22'h064000, 2'd0, 7, 0,       0, 1};
    t1[5] = '{1'b1, 1'b0, 22'h064000, 2'd0, 6, 'h4000, 0, 0};
    t1[6] = '{1'b1, 1'b0, 22'h064000, 2'd0, 6, 'h8000, 0, 0};
    t1[7] = '{1'b1, 1'b0, 22'h064000, 2'd0, 6, 'hC000, 0, 0};
    t1[8] = '{1'b1, 1'b0, 22'h064000, 2'd0, 7, 0,       0, 1};

    NRST = 1'b0; EN = 1'b0; CFG_LD = 1'b0; FCW = '0; MODE = '0;
    model_reset();
    #12 check_reset("reset");
    NRST = 1'b1;

    // MODE 0, FCW 6.25
    run_t1(9, "t1");

    // MODE 2, FCW 10.5: mean and range
    async_reset("t2_rst");
    apply(1'b0, 1'b1, 22'h0A8000, 2'd2);
    ysum = 0; bad = 0;
    for (int k = 0; k < 1024; k++) begin
      apply(1'b1, 1'b0, 22'h0A8000, 2'd2);
      check_model("t2");
      ysum += int'($signed(DSM_OUT));
      if (MMD_DCW < 7 || MMD_DCW > 14) bad++;
      if ($signed(PHE) <= -(4 * ONE)) bad++;
    end
    chk_rng("t2_ysum", ysum, 509, 515);
    chk("t2_range_violations", bad, 0);

    // MODE 2 at the top of the range: clamping
    apply(1'b1, 1'b1, 22'h3FFFFF, 2'd2);
    check_model("t3_ld");
    sat_seen = 0; bad = 0;
    for (int k = 0; k < 200; k++) begin
      apply(1'b1, 1'b0, 22'h3FFFFF, 2'd2);
      check_model("t3");
      if (SAT) begin
        sat_seen++;
        if (MMD_DCW != 6'd63) bad++;
      end
    end
    chk_rng("t3_sat_cycles", sat_seen, 1, 200);
    chk("t3_sat_not_at_max", bad, 0);

    // MODE 1 with a 50-cycle freeze
    async_reset("t4_rst");
    apply(1'b0, 1'b1, 22'h05A123, 2'd1);
    for (int k = 0; k < 30; k++) begin apply(1'b1, 1'b0, 22'h05A123, 2'd1); check_model("t4_pre"); end
    for (int k = 0; k < 50; k++) begin apply(1'b0, 1'b0, 22'h05A123, 2'd1); check_model("t4_hold"); end
    for (int k = 0; k < 30; k++) begin apply(1'b1, 1'b0, 22'h05A123, 2'd1); check_model("t4_post"); end

    // Mode switch 2 -> 0 mid-run
    apply(1'b1, 1'b1, 22'h064000, 2'd2);
    for (int k = 0; k < 20; k++) begin apply(1'b1, 1'b0, 22'h064000, 2'd2); check_model("t5_m2"); end
    apply(1'b1, 1'b1, 22'h064000, 2'd0);
    check_model("t5_sw");
    chk("t5_acc2", int'(dut.acc2_q), 0);
    chk("t5_acc3", int'(dut.acc3_q), 0);
    chk("t5_hist", int'({dut.c2_d1_q, dut.c3_d1_q, dut.c3_d2_q}), 0);
    for (int k = 0; k < 12; k++) begin apply(1'b1, 1'b0, 22'h064000, 2'd0); check_model("t5_m0"); end

    // Asynchronous reset between edges, then replay the MODE 0 sequence
    async_reset("t6_rst0");
    run_t1(5, "t6a");
    async_reset("t6_rst");
    run_t1(9, "t6b");

    // Randomized
    async_reset("rnd_rst");
    for (int k = 0; k < 1500; k++) begin
      en_r  = ($urandom_range(0, 3) != 0);
      ld_r  = ($urandom_range(0, 15) == 0);
      fcw_r = 22'($urandom_range(0, 32'h3FFFFF));
      apply(en_r, ld_r, fcw_r, 2'($urandom_range(0, 3)));
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
